// File: rtl/poly_wave_osc.sv
// Time-multiplexed oscillator bank: one phase accumulator per voice, swept once per
// step_in, streaming one signed sample per voice through a three-stage output pipe.
module poly_wave_osc #(
   parameter int NUM_VOICES  = 8,
   parameter int PHASE_WIDTH = 32,
   parameter int LUT_ADDR    = 8,
   parameter int OUT_WIDTH   = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          step_in,
   input  logic                          cfg_we_in,
   input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in,
   input  logic [PHASE_WIDTH-1:0]        cfg_incr_in,
   input  logic [1:0]                    cfg_wave_in,
   input  logic [NUM_VOICES-1:0]         phase_rst_in,
   output logic [OUT_WIDTH-1:0]          sample_out,
   output logic [$clog2(NUM_VOICES)-1:0] voice_out,
   output logic                          valid_out,
   output logic                          last_out,
   output logic                          busy_out,
   output logic                          overrun_out
);
   localparam int VW    = $clog2(NUM_VOICES);
   localparam int P     = PHASE_WIDTH;
   localparam int W     = OUT_WIDTH;
   localparam int LUT_N = 2**LUT_ADDR;
   // Only the top TB phase bits ever reach a waveform, so only those are piped.
   localparam int TB    = (LUT_ADDR + 2 > W + 1) ? LUT_ADDR + 2 : W + 1;
   localparam logic [W-1:0] AMP = W'((2**(W-1)) - 1);
   localparam real AMP_R = (2.0**(W-1)) - 1.0;
   localparam real PI    = 3.14159265358979323846;

   typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

   logic [W-1:0] sine_rom [LUT_N];
   for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
      localparam int ENTRY = $rtoi(AMP_R * $sin(2.0 * PI * (gi + 0.5) / (4.0 * LUT_N)) + 0.5);
      assign sine_rom[gi] = ENTRY[W-1:0];
   end

   state_t                state_q, state_d;
   logic [VW-1:0]         cnt_q, cnt_d;
   logic                  overrun_q, overrun_d;
   logic [P-1:0]          phase_q [NUM_VOICES];
   logic [P-1:0]          phase_d [NUM_VOICES];
   logic [P-1:0]          incr_q  [NUM_VOICES];
   logic [P-1:0]          incr_d  [NUM_VOICES];
   logic [1:0]            wave_q  [NUM_VOICES];
   logic [1:0]            wave_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] pend_q, pend_d;
   logic                  svc;
   logic [P-1:0]          svc_phase;

   logic                  s1_valid_q, s1_valid_d;
   logic [VW-1:0]         s1_voice_q, s1_voice_d;
   logic [TB-1:0]         s1_ph_q, s1_ph_d;
   logic [1:0]            s1_wave_q, s1_wave_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [VW-1:0]         s2_voice_q, s2_voice_d;
   logic                  s2_sine_q, s2_sine_d;
   logic                  s2_neg_q, s2_neg_d;
   logic [W-1:0]          s2_other_q, s2_other_d;
   logic [W-1:0]          lut_q;
   logic [LUT_ADDR-1:0]   lut_addr;
   logic [W-1:0]          tri_val;
   logic [W-1:0]          sample_q, sample_d;
   logic [VW-1:0]         voice_q, voice_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;

   assign svc = (state_q == S_SWEEP);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      overrun_d = step_in && (state_q == S_SWEEP);
      if (state_q == S_IDLE) begin
         if (step_in) begin
            state_d = S_SWEEP;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == VW'(NUM_VOICES - 1)) begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
      end
   end

   // A pending note-on makes the serviced phase 0, so the write-back is just incr.
   always_comb begin
      phase_d   = phase_q;
      incr_d    = incr_q;
      wave_d    = wave_q;
      pend_d    = pend_q;
      svc_phase = pend_q[cnt_q] ? '0 : phase_q[cnt_q];
      if (svc) begin
         phase_d[cnt_q] = svc_phase + incr_q[cnt_q];
         pend_d[cnt_q]  = 1'b0;
      end
      pend_d = pend_d | phase_rst_in;
      if (cfg_we_in) begin
         incr_d[cfg_voice_in] = cfg_incr_in;
         wave_d[cfg_voice_in] = cfg_wave_in;
      end
   end

   always_comb begin
      s1_valid_d = svc;
      s1_voice_d = cnt_q;
      s1_ph_d    = svc_phase[P-1 -: TB];
      s1_wave_d  = wave_q[cnt_q];

      lut_addr = s1_ph_q[TB-3 -: LUT_ADDR];
      if (s1_ph_q[TB-2]) begin
         lut_addr = ~lut_addr;
      end
      tri_val = s1_ph_q[TB-2 -: W];
      if (s1_ph_q[TB-1]) begin
         tri_val = ~tri_val;
      end
      s2_valid_d = s1_valid_q;
      s2_voice_d = s1_voice_q;
      s2_sine_d  = (s1_wave_q == 2'd0);
      s2_neg_d   = s1_ph_q[TB-1];
      case (s1_wave_q)
         2'd1:    s2_other_d = {~s1_ph_q[TB-1], s1_ph_q[TB-2 -: W-1]};
         2'd2:    s2_other_d = s1_ph_q[TB-1] ? -AMP : AMP;
         2'd3:    s2_other_d = {~tri_val[W-1], tri_val[W-2:0]};
         default: s2_other_d = '0;
      endcase

      sample_d = sample_q;
      voice_d  = voice_q;
      if (s2_valid_q) begin
         sample_d = s2_sine_q ? (s2_neg_q ? -lut_q : lut_q) : s2_other_q;
         voice_d  = s2_voice_q;
      end
      valid_d = s2_valid_q;
      last_d  = s2_valid_q && (s2_voice_q == VW'(NUM_VOICES - 1));
   end

   always_ff @(posedge clk_in) begin
      lut_q <= sine_rom[lut_addr];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            phase_q[i] <= '0;
            incr_q[i]  <= '0;
            wave_q[i]  <= 2'd0;
         end
         pend_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_voice_q <= '0;
         s1_ph_q    <= '0;
         s1_wave_q  <= 2'd0;
         s2_valid_q <= 1'b0;
         s2_voice_q <= '0;
         s2_sine_q  <= 1'b0;
         s2_neg_q   <= 1'b0;
         s2_other_q <= '0;
         sample_q   <= '0;
         voice_q    <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         incr_q     <= incr_d;
         wave_q     <= wave_d;
         pend_q     <= pend_d;
         s1_valid_q <= s1_valid_d;
         s1_voice_q <= s1_voice_d;
         s1_ph_q    <= s1_ph_d;
         s1_wave_q  <= s1_wave_d;
         s2_valid_q <= s2_valid_d;
         s2_voice_q <= s2_voice_d;
         s2_sine_q  <= s2_sine_d;
         s2_neg_q   <= s2_neg_d;
         s2_other_q <= s2_other_d;
         sample_q   <= sample_d;
         voice_q    <= voice_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
      end
   end

   assign sample_out  = sample_q;
   assign voice_out   = voice_q;
   assign valid_out   = valid_q;
   assign last_out    = last_q;
   assign busy_out    = (state_q == S_SWEEP);
   assign overrun_out = overrun_q;

endmodule

// File: tb/tb_poly_wave_osc.sv
// Bench for poly_wave_osc: directed scenarios plus randomized sweeps, every sample
// checked against a transaction-level model of the voice bank.
module tb_poly_wave_osc;
   localparam int NV = 8;
   localparam real PI = 3.14159265358979323846;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          step_in;
   logic          cfg_we_in;
   logic [2:0]    cfg_voice_in;
   logic [31:0]   cfg_incr_in;
   logic [1:0]    cfg_wave_in;
   logic [NV-1:0] phase_rst_in;
   logic [15:0]   sample_out;
   logic [2:0]    voice_out;
   logic          valid_out;
   logic          last_out;
   logic          busy_out;
   logic          overrun_out;

   poly_wave_osc #(.NUM_VOICES(NV), .PHASE_WIDTH(32), .LUT_ADDR(8), .OUT_WIDTH(16)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .step_in(step_in), .cfg_we_in(cfg_we_in),
      .cfg_voice_in(cfg_voice_in), .cfg_incr_in(cfg_incr_in), .cfg_wave_in(cfg_wave_in),
      .phase_rst_in(phase_rst_in), .sample_out(sample_out), .voice_out(voice_out),
      .valid_out(valid_out), .last_out(last_out), .busy_out(busy_out),
      .overrun_out(overrun_out)
   );

   initial forever #5 clk_in = ~clk_in;

   typedef struct {
      int cyc;
      int voice;
      int sample;
   } exp_t;

   exp_t          expq[$];
   exp_t          mon_e;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_sweep = 0;
   int            got_s [NV];
   bit [31:0]     m_phase [NV];
   bit [31:0]     m_incr  [NV];
   bit [1:0]      m_wave  [NV];
   bit [NV-1:0]   m_pend;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Ideal full-cycle sine sampled at bin centres, plus the plain arithmetic shapes.
   function automatic int ref_sample(input bit [1:0] w, input bit [31:0] ph);
      int  u;
      real a;
      case (w)
         2'd0: begin
            a = 32767.0 * $sin(2.0 * PI * (real'(ph[31:22]) + 0.5) / 1024.0);
            return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
         end
         2'd1: return int'(ph[31:16]) - 32768;
         2'd2: return ph[31] ? -32767 : 32767;
         default: begin
            u = int'(ph[30:15]);
            if (ph[31]) u = 65535 - u;
            return u - 32768;
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_phase[v] = 32'd0;
         m_incr[v]  = 32'd0;
         m_wave[v]  = 2'd0;
      end
      m_pend = '0;
   endtask

   // One sweep; an injected change lands after voice inj_at-1 is serviced.
   task automatic model_sweep(input int c0, input int inj_at, input bit [NV-1:0] mask,
                              input bit we, input bit [2:0] iv, input bit [31:0] incr,
                              input bit [1:0] wave);
      for (int v = 0; v < NV; v++) begin
         bit [31:0] ph;
         ph = m_pend[v] ? 32'd0 : m_phase[v];
         expq.push_back(exp_t'{c0 + 3 + v, v, ref_sample(m_wave[v], ph)});
         m_phase[v] = ph + m_incr[v];
         m_pend[v]  = 1'b0;
         if (v == inj_at - 1) begin
            m_pend = m_pend | mask;
            if (we) begin
               m_incr[iv] = incr;
               m_wave[iv] = wave;
            end
         end
      end
   endtask

   always @(posedge clk_in) begin
      #1;
      if (rst_n_in) begin
         if (valid_out) begin
            if (expq.size() == 0) begin
               check_val("spurious_valid", 1, 0);
            end else begin
               mon_e = expq.pop_front();
               check_val("sample_cycle", cyc, mon_e.cyc);
               check_val("voice", voice_out, mon_e.voice);
               check_val("sample", $signed(sample_out), mon_e.sample);
               check_val("last", last_out, mon_e.voice == NV - 1);
               got_s[voice_out] = int'($signed(sample_out));
            end
         end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
            check_val("missing_valid", 0, 1);
            void'(expq.pop_front());
         end
      end
   end

   // Called just after a negedge with the DUT idle; returns likewise.
   task automatic run_sweep(input int ovr_at, input int inj_at, input bit [NV-1:0] mask,
                            input bit we, input bit [2:0] iv, input bit [31:0] incr,
                            input bit [1:0] wave);
      n_sweep++;
      $display("sweep %0d: overrun_at=%0d inject_at=%0d mask=%02h we=%0d voice=%0d incr=%08h wave=%0d",
               n_sweep, ovr_at, inj_at, mask, we, iv, incr, wave);
      step_in = 1'b1;
      model_sweep(cyc + 1, inj_at, mask, we, iv, incr, wave);
      @(negedge clk_in);
      step_in = 1'b0;
      check_val("busy_start", busy_out, 1);
      check_val("overrun_start", overrun_out, 0);
      for (int k = 1; k <= NV; k++) begin
         if (k == ovr_at) step_in = 1'b1;
         if (k == inj_at) begin
            phase_rst_in = mask;
            cfg_we_in    = we;
            cfg_voice_in = iv;
            cfg_incr_in  = incr;
            cfg_wave_in  = wave;
         end
         @(negedge clk_in);
         step_in      = 1'b0;
         phase_rst_in = '0;
         cfg_we_in    = 1'b0;
         check_val("overrun", overrun_out, k == ovr_at);
      end
      check_val("busy_end", busy_out, 0);
   endtask

   task automatic plain_sweep();
      run_sweep(0, 0, '0, 1'b0, 3'd0, 32'd0, 2'd0);
      repeat (4) @(negedge clk_in);
   endtask

   task automatic cfg(input bit [2:0] v, input bit [31:0] incr, input bit [1:0] wave);
      cfg_we_in = 1'b1; cfg_voice_in = v; cfg_incr_in = incr; cfg_wave_in = wave;
      m_incr[v] = incr;
      m_wave[v] = wave;
      @(negedge clk_in);
      cfg_we_in = 1'b0;
   endtask

   task automatic prst(input bit [NV-1:0] mask);
      phase_rst_in = mask;
      m_pend = m_pend | mask;
      @(negedge clk_in);
      phase_rst_in = '0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_sample"}, sample_out, 0);
      check_val({tag, "_voice"}, voice_out, 0);
      check_val({tag, "_valid"}, valid_out, 0);
      check_val({tag, "_last"}, last_out, 0);
      check_val({tag, "_busy"}, busy_out, 0);
      check_val({tag, "_overrun"}, overrun_out, 0);
   endtask

   initial begin
      int sine_q[4];
      sine_q = '{101, 32767, -101, -32767};
      rst_n_in = 1'b0; step_in = 1'b0; cfg_we_in = 1'b0; cfg_voice_in = '0;
      cfg_incr_in = '0; cfg_wave_in = '0; phase_rst_in = '0;
      model_reset();
      #12;
      check_idle_outputs("reset");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);

      // Fresh reset: every voice is sine at phase 0.
      plain_sweep();
      for (int v = 0; v < NV; v++) check_val("reset_sine", got_s[v], 101);

      cfg(3'd2, 32'h4000_0000, 2'd0);
      for (int i = 0; i < 5; i++) begin
         plain_sweep();
         check_val("sine_quadrant", got_s[2], sine_q[i % 4]);
      end

      cfg(3'd0, 32'h1000_0000, 2'd1);
      prst(8'h01);
      for (int i = 0; i < 17; i++) begin
         plain_sweep();
         check_val("saw_ramp", got_s[0], -32768 + 4096 * (i % 16));
      end
      cfg(3'd0, 32'h1000_0000, 2'd2);
      prst(8'h01);
      for (int i = 0; i < 16; i++) begin
         plain_sweep();
         check_val("square", got_s[0], (i < 8) ? 32767 : -32767);
      end

      run_sweep(4, 0, '0, 1'b0, 3'd0, 32'd0, 2'd0);
      run_sweep(8, 0, '0, 1'b0, 3'd0, 32'd0, 2'd0);
      repeat (4) @(negedge clk_in);

      // Note-on and config write landing in voice 3's own service cycle.
      cfg(3'd3, 32'h0100_0000, 2'd1);
      plain_sweep();
      plain_sweep();
      run_sweep(0, 4, 8'h08, 1'b1, 3'd3, 32'h2000_0000, 2'd3);
      repeat (4) @(negedge clk_in);
      check_val("v3_old_cfg", got_s[3], -32768 + 2 * 256);
      plain_sweep();
      check_val("v3_note_on", got_s[3], -32768);
      plain_sweep();
      check_val("v3_new_incr", got_s[3], -16384);

      // Asynchronous reset in the middle of a sweep.
      step_in = 1'b1;
      model_sweep(cyc + 1, 0, '0, 1'b0, 3'd0, 32'd0, 2'd0);
      @(negedge clk_in);
      step_in = 1'b0;
      repeat (4) @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1 check_idle_outputs("async_reset");
      expq.delete();
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      plain_sweep();
      for (int v = 0; v < NV; v++) check_val("post_reset_sine", got_s[v], 101);

      for (int it = 0; it < 60; it++) begin
         int ovr, inj;
         if ($urandom_range(0, 1) == 1) begin
            cfg(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1 << 24)),
                2'($urandom_range(0, 3)));
         end
         if ($urandom_range(0, 3) == 0) prst(8'($urandom));
         ovr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, NV) : 0;
         inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, NV) : 0;
         run_sweep(ovr, inj, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, 2'($urandom_range(0, 3)));
      end
      repeat (6) @(negedge clk_in);
      check_val("queue_drained", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
